// File: rtl/i2c_write_burst_vr_if.sv
// Bundle of request, payload, pad and status signals for the I2C write burst master.
// The master modport is the controller side; the slave modport is the requester/pad side.
interface i2c_write_burst_vr_if #(
    parameter int unsigned MAX_BYTES = 4
);
    localparam int unsigned NB_W = $clog2(MAX_BYTES + 1);
    localparam int unsigned DW   = 8 * MAX_BYTES;

    logic            GO;
    logic [7:0]      SLAVE_ADDRESS;
    logic [7:0]      POINTER;
    logic [DW-1:0]   DATA;
    logic [NB_W-1:0] NBYTES;
    logic            POLL_EN;
    logic            SDAI;
    logic            SDAO;
    logic            SCLO;
    logic            END_OK;
    logic            ACK_OK;
    logic            NACK_ERR;
    logic [7:0]      POLL_CNT;
    logic [3:0]      ST;

    modport master (
        input  GO, SLAVE_ADDRESS, POINTER, DATA, NBYTES, POLL_EN, SDAI,
        output SDAO, SCLO, END_OK, ACK_OK, NACK_ERR, POLL_CNT, ST
    );

    modport slave (
        output GO, SLAVE_ADDRESS, POINTER, DATA, NBYTES, POLL_EN, SDAI,
        input  SDAO, SCLO, END_OK, ACK_OK, NACK_ERR, POLL_CNT, ST
    );
endinterface

// File: rtl/i2c_write_burst_vr.sv
// I2C write master: address byte, pointer byte, then up to MAX_BYTES data bytes,
// with optional bounded ACK polling of the address phase. One state step per PT_CK edge.
module i2c_write_burst_vr #(
    parameter int unsigned MAX_BYTES  = 4,
    parameter int unsigned POLL_LIMIT = 255,
    parameter int unsigned SETTLE     = 2
) (
    input  logic                 PT_CK,
    input  logic                 RESET,
    i2c_write_burst_vr_if.master bus
);
    localparam int unsigned NB_W = $clog2(MAX_BYTES + 1);
    localparam int unsigned BI_W = $clog2(MAX_BYTES + 2);
    localparam int unsigned DW   = 8 * MAX_BYTES;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_START   = 4'd1,
        S_BIT0    = 4'd2,
        S_BIT1    = 4'd3,
        S_BIT2    = 4'd4,
        S_BIT3    = 4'd5,
        S_STOP0   = 4'd6,
        S_STOP1   = 4'd7,
        S_STOP2   = 4'd8,
        S_SETTLE  = 4'd9,
        S_DONE    = 4'd10,
        S_WAITLOW = 4'd11
    } state_e;

    state_e          state_q, state_d;
    logic            sdao_q, sdao_d;
    logic            sclo_q, sclo_d;
    logic            end_ok_q, end_ok_d;
    logic            ack_ok_q, ack_ok_d;
    logic            nack_err_q, nack_err_d;
    logic [7:0]      poll_cnt_q, poll_cnt_d;
    logic            armed_q, armed_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      ptr_q, ptr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [NB_W-1:0] nbytes_q, nbytes_d;
    logic            poll_en_q, poll_en_d;
    logic [8:0]      shift_q, shift_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [BI_W-1:0] byte_idx_q, byte_idx_d;
    logic [7:0]      settle_q, settle_d;
    logic            nack_q, nack_d;
    logic            retry_q, retry_d;

    logic            accept_c;
    logic            ack_slot_c;
    logic            got_ack_c;
    logic            last_byte_c;
    logic            can_retry_c;
    logic [NB_W-1:0] nbytes_clamp_c;
    logic [7:0]      next_byte_c;

    assign accept_c       = bus.GO && armed_q;
    assign ack_slot_c     = (bit_cnt_q == 4'd8);
    assign got_ack_c      = !bus.SDAI;
    assign last_byte_c    = (byte_idx_q == (BI_W'(nbytes_q) + BI_W'(1)));
    assign can_retry_c    = (byte_idx_q == '0) && poll_en_q && (poll_cnt_q < 8'(POLL_LIMIT));
    assign nbytes_clamp_c = (bus.NBYTES > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : bus.NBYTES;

    // Byte following the current one: pointer after address, else data[byte_idx-1].
    always_comb begin
        next_byte_c = ptr_q;
        for (int unsigned k = 0; k < MAX_BYTES; k++) begin
            if (byte_idx_q == BI_W'(k + 1)) next_byte_c = data_q[8*k +: 8];
        end
    end

    // State and datapath register
    always_ff @(posedge PT_CK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            sdao_q     <= 1'b1;
            sclo_q     <= 1'b1;
            end_ok_q   <= 1'b1;
            ack_ok_q   <= 1'b0;
            nack_err_q <= 1'b0;
            poll_cnt_q <= 8'd0;
            armed_q    <= 1'b1;
            addr_q     <= 8'd0;
            ptr_q      <= 8'd0;
            data_q     <= '0;
            nbytes_q   <= '0;
            poll_en_q  <= 1'b0;
            shift_q    <= 9'h1FF;
            bit_cnt_q  <= 4'd0;
            byte_idx_q <= '0;
            settle_q   <= 8'd0;
            nack_q     <= 1'b0;
            retry_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sdao_q     <= sdao_d;
            sclo_q     <= sclo_d;
            end_ok_q   <= end_ok_d;
            ack_ok_q   <= ack_ok_d;
            nack_err_q <= nack_err_d;
            poll_cnt_q <= poll_cnt_d;
            armed_q    <= armed_d;
            addr_q     <= addr_d;
            ptr_q      <= ptr_d;
            data_q     <= data_d;
            nbytes_q   <= nbytes_d;
            poll_en_q  <= poll_en_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            settle_q   <= settle_d;
            nack_q     <= nack_d;
            retry_q    <= retry_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (accept_c) state_d = S_START;
            S_START:   state_d = S_BIT0;
            S_BIT0:    state_d = S_BIT1;
            S_BIT1:    state_d = S_BIT2;
            S_BIT2:    state_d = S_BIT3;
            S_BIT3: begin
                if (!ack_slot_c)                     state_d = S_BIT0;
                else if (got_ack_c && !last_byte_c)  state_d = S_BIT0;
                else                                 state_d = S_STOP0;
            end
            S_STOP0:   state_d = S_STOP1;
            S_STOP1:   state_d = S_STOP2;
            S_STOP2:   state_d = retry_q ? S_SETTLE : S_DONE;
            S_SETTLE:  if (settle_q == 8'(SETTLE - 1)) state_d = S_START;
            S_DONE:    state_d = S_WAITLOW;
            S_WAITLOW: if (!bus.GO) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; the bus pins are registered, so each state
    // drives its pattern on the edge at which it executes.
    always_comb begin
        sdao_d     = sdao_q;
        sclo_d     = sclo_q;
        end_ok_d   = end_ok_q;
        ack_ok_d   = ack_ok_q;
        nack_err_d = nack_err_q;
        poll_cnt_d = poll_cnt_q;
        armed_d    = armed_q;
        addr_d     = addr_q;
        ptr_d      = ptr_q;
        data_d     = data_q;
        nbytes_d   = nbytes_q;
        poll_en_d  = poll_en_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        settle_d   = settle_q;
        nack_d     = nack_q;
        retry_d    = retry_q;
        unique case (state_q)
            S_IDLE: begin
                sdao_d = 1'b1;
                sclo_d = 1'b1;
                if (accept_c) begin
                    addr_d     = bus.SLAVE_ADDRESS;
                    ptr_d      = bus.POINTER;
                    data_d     = bus.DATA;
                    nbytes_d   = nbytes_clamp_c;
                    poll_en_d  = bus.POLL_EN;
                    end_ok_d   = 1'b0;
                    ack_ok_d   = 1'b0;
                    nack_err_d = 1'b0;
                    poll_cnt_d = 8'd0;
                    armed_d    = 1'b0;
                    nack_d     = 1'b0;
                    retry_d    = 1'b0;
                end
            end
            S_START: begin
                sdao_d     = 1'b0;
                sclo_d     = 1'b1;
                poll_cnt_d = (poll_cnt_q == 8'hFF) ? poll_cnt_q : poll_cnt_q + 8'd1;
                shift_d    = {addr_q, 1'b1};
                bit_cnt_d  = 4'd0;
                byte_idx_d = '0;
                retry_d    = 1'b0;
            end
            S_BIT0: sclo_d = 1'b0;
            S_BIT1: begin
                sdao_d  = shift_q[8];
                shift_d = {shift_q[7:0], 1'b0};
            end
            S_BIT2: sclo_d = 1'b1;
            S_BIT3: begin
                sclo_d    = 1'b0;
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (ack_slot_c) begin
                    if (got_ack_c) begin
                        if (!last_byte_c) begin
                            byte_idx_d = byte_idx_q + BI_W'(1);
                            shift_d    = {next_byte_c, 1'b1};
                            bit_cnt_d  = 4'd0;
                        end
                    end else if (can_retry_c) begin
                        retry_d = 1'b1;
                    end else begin
                        nack_d = 1'b1;
                    end
                end
            end
            S_STOP0: begin
                sdao_d = 1'b0;
                sclo_d = 1'b0;
            end
            S_STOP1: begin
                sdao_d = 1'b0;
                sclo_d = 1'b1;
            end
            S_STOP2: begin
                sdao_d   = 1'b1;
                sclo_d   = 1'b1;
                settle_d = 8'd0;
            end
            S_SETTLE: begin
                sdao_d   = 1'b1;
                sclo_d   = 1'b1;
                settle_d = settle_q + 8'd1;
            end
            S_DONE: begin
                end_ok_d   = 1'b1;
                ack_ok_d   = !nack_q;
                nack_err_d = nack_q;
            end
            S_WAITLOW: begin
                sdao_d = 1'b1;
                sclo_d = 1'b1;
                if (!bus.GO) armed_d = 1'b1;
            end
            default: begin
                sdao_d = 1'b1;
                sclo_d = 1'b1;
            end
        endcase
    end

    assign bus.SDAO     = sdao_q;
    assign bus.SCLO     = sclo_q;
    assign bus.END_OK   = end_ok_q;
    assign bus.ACK_OK   = ack_ok_q;
    assign bus.NACK_ERR = nack_err_q;
    assign bus.POLL_CNT = poll_cnt_q;
    assign bus.ST       = state_q;
endmodule

// File: doc/i2c_write_burst_vr.md
Name: i2c_write_burst_vr

Overview:
Parametrised I2C write master, successor to the single-pointer VCM writer. It sends the slave address byte, then a register pointer byte, then 0..MAX_BYTES data bytes in one transaction. Optional ACK polling retries the address phase until the slave wakes; the retry count is bounded. It sits between the camera/VCM control FSMs and the open-drain SDA/SCL pad logic, and is clocked by the I2C phase tick clock PT_CK.

Parameters:
MAX_BYTES, 4, maximum number of data bytes written after the pointer (1..16)
POLL_LIMIT, 255, maximum address-phase attempts when polling (1..255)
SETTLE, 2, idle PT_CK cycles with bus released between a polled NACK stop and the retry start (1..255)

Ports:
PT_CK  input  1  I2C phase clock; one state step per rising edge
RESET  input  1  synchronous, active-high reset
GO  input  1  transaction request, level-sensitive, rearmed by GO low
SLAVE_ADDRESS  input  8  address byte including R/W bit (bit0 = 0 for write), sent MSB first
POINTER  input  8  register pointer byte
DATA  input  8*MAX_BYTES  data bytes; byte k is DATA[8k+7:8k]; byte 0 is sent first
NBYTES  input  $clog2(MAX_BYTES+1)  number of data bytes to send; values above MAX_BYTES are clamped to MAX_BYTES
POLL_EN  input  1  1 = retry the address phase on NACK
SDAI  input  1  SDA pad readback
SDAO  output  1  SDA drive (1 = released)
SCLO  output  1  SCL drive (1 = released)
END_OK  output  1  1 = idle/done, 0 = busy
ACK_OK  output  1  1 = every byte of the last transaction was ACKed
NACK_ERR  output  1  1 = last transaction aborted on NACK or poll limit
POLL_CNT  output  8  number of address attempts in the last transaction
ST  output  4  state code, for test only

Behaviour:
- Reset: SDAO=1, SCLO=1, END_OK=1, ACK_OK=0, NACK_ERR=0, POLL_CNT=0, ST=IDLE, armed=1. Reset mid-transaction releases the bus at once; no STOP is generated.
- States: IDLE, START, BIT0..BIT3, STOP0..STOP2, SETTLE, DONE, WAITLOW.
- IDLE: SDAO=SCLO=1. If GO=1 and armed: latch SLAVE_ADDRESS, POINTER, DATA and clamped NBYTES; set END_OK=0, ACK_OK=0, NACK_ERR=0, POLL_CNT=0, armed=0; go to START. Accept edge = edge 0.
- START: {SDAO,SCLO}=01 (SDA falls while SCL is high); increment POLL_CNT, saturating at 255; load shifter {byte,1'b1}; bit count = 0.
- Each bit takes 4 edges:
  - BIT0: SCLO=0.
  - BIT1: SDAO = shifter MSB, then shift.
  - BIT2: SCLO=1.
  - BIT3: SCLO=0; count+1.
- 9 bits per byte; bit 9 is the released ACK slot (SDAO=1). SDAI is sampled at the BIT3 edge of bit 9; ACK = SDAI==0.
- Byte sequence: address, pointer, then data bytes 0..NBYTES-1. On ACK of the last byte, go to STOP0.
- STOP0 drives 00, STOP1 drives 01, STOP2 drives 11, then DONE.
- DONE: END_OK=1; ACK_OK=1 unless a NACK occurred; go to WAITLOW.
- WAITLOW: SDAO=SCLO=1. Set armed=1 when GO=0, then go to IDLE. GO held high therefore never starts a second transaction.
- Address NACK with POLL_EN=1 and POLL_CNT<POLL_LIMIT: STOP0..STOP2, then SETTLE for SETTLE edges with the bus released, then START again.
- Address NACK with POLL_EN=0 or POLL_CNT==POLL_LIMIT: STOP, then DONE with NACK_ERR=1.
- NACK on the pointer or any data byte: STOP, then DONE with NACK_ERR=1, ACK_OK=0. There is no retry.
- Latency with no NACK: END_OK rises on edge 5+36*(2+N) after the accept edge (N = clamped NBYTES). Each polled retry adds 36+3+SETTLE+1 edges.
- GO is ignored while busy. Inputs may change after the accept edge without effect.

Test Plan:
1. POLL_EN=0, NBYTES=0, SLAVE_ADDRESS=8'h18, POINTER=8'hA5, slave ACKs every byte -> SDA shifts 0x18 then 0xA5 MSB first; END_OK rises at edge 77; ACK_OK=1, NACK_ERR=0, POLL_CNT=1.
2. NBYTES=3, DATA byte0..byte2 = 8'h11, 8'h22, 8'h33 (DATA[23:0]=24'h332211), all ACKed -> bytes 18, A5, 11, 22, 33 appear on the wire in that order; END_OK rises at edge 185; no bus activity after STOP.
3. POLL_EN=1, slave NACKs the first 2 address phases, then ACKs -> STOP pattern 00/01/11 after each NACK, SETTLE=2 idle edges, 3 START conditions total; POLL_CNT=3, ACK_OK=1.
4. POLL_EN=1, POLL_LIMIT=4, slave never ACKs -> exactly 4 attempts; END_OK=1, NACK_ERR=1, ACK_OK=0, POLL_CNT=4.
5. NACK on data byte 1 of NBYTES=3 -> STOP follows immediately, byte 2 is never sent, NACK_ERR=1; GO held high afterwards -> no restart until GO falls and rises again.
6. RESET asserted during bit 5 of the pointer byte -> the next edge gives SDAO=1, SCLO=1, END_OK=1, ST=IDLE; NBYTES=7 with MAX_BYTES=4 is clamped to 4 data bytes sent.
